// File: rtl/ptw_pkg.sv
// Shared types and helpers for the page-table-walker pending-walk buffer.
package ptw_pkg;

   typedef enum logic [2:0] {
      ST_FREE     = 3'd0,
      ST_WAIT     = 3'd1,
      ST_MERGED   = 3'd2,
      ST_INFLIGHT = 3'd3,
      ST_DONE     = 3'd4,
      ST_ZOMBIE   = 3'd5
   } entry_state_e;

   // Matching key; instances zero-extend their tag/level into these fields.
   localparam int unsigned KEY_TAG_MAX = 64;
   localparam int unsigned KEY_LVL_MAX = 8;

   typedef struct packed {
      logic [KEY_TAG_MAX-1:0] tag;
      logic [KEY_LVL_MAX-1:0] level;
   } ptw_key_t;

   function automatic int unsigned calc_lw(input int unsigned levels);
      return (levels > 1) ? $clog2(levels) : 1;
   endfunction

   function automatic int unsigned calc_idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // PEncoder: index of the lowest set bit (0 when none set).
   function automatic int unsigned pencoder(input logic [63:0] vec);
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (!found && vec[i]) begin
            idx   = i;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/ptw_walk_buffer_age_sel.sv
// Oldest-entry picker over an "older-than" age matrix.
// rows[i][j] set means entry j is older than entry i.
module age_matrix_select #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic [DEPTH-1:0]            req,
   input  logic [DEPTH-1:0][DEPTH-1:0] rows,
   output logic [DEPTH-1:0]            pick,
   output logic [IDX_W-1:0]            pick_idx,
   output logic                        any
);

   // A requester is oldest when no other requester is older than it.
   always_comb begin
      pick     = '0;
      pick_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (req[i] && ((rows[i] & req) == '0)) pick[i] = 1'b1;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (pick[i]) pick_idx = IDX_W'(i);
      end
   end

   assign any = |pick;

endmodule

// File: rtl/ptw_walk_buffer.sv
// Pending page-table-walk buffer: tracks misses, issues oldest-first under an
// in-flight credit limit, merges same-{tag,level} walks and drains results.
module ptw_walk_buffer
   import ptw_pkg::*;
#(
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned TAG_WIDTH    = 18,
   parameter int unsigned DATA_WIDTH   = 48,
   parameter int unsigned LEVELS       = 2,
   parameter int unsigned MAX_INFLIGHT = 2,
   parameter int unsigned IDX_W        = calc_idx_w(DEPTH),
   parameter int unsigned LW           = calc_lw(LEVELS),
   parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  alloc_en,
   input  logic [TAG_WIDTH-1:0]  alloc_tag,
   input  logic [LW-1:0]         alloc_level,
   input  logic [DATA_WIDTH-1:0] alloc_data,
   output logic                  full,
   output logic                  issue_valid,
   input  logic                  issue_ready,
   output logic [IDX_W-1:0]      issue_idx,
   output logic [TAG_WIDTH-1:0]  issue_tag,
   output logic [LW-1:0]         issue_level,
   output logic [DATA_WIDTH-1:0] issue_data,
   input  logic                  resp_valid,
   input  logic [IDX_W-1:0]      resp_idx,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [TAG_WIDTH-1:0]  wb_tag,
   output logic [LW-1:0]         wb_level,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_leader,
   output logic [CNT_W-1:0]      inflight_cnt
);

   entry_state_e                  state_q [DEPTH];
   entry_state_e                  state_d [DEPTH];
   logic [DEPTH-1:0]              leader_q, leader_d;
   logic [TAG_WIDTH-1:0]          tag_q   [DEPTH];
   logic [LW-1:0]                 lvl_q   [DEPTH];
   logic [DATA_WIDTH-1:0]         data_q  [DEPTH];
   logic [DEPTH-1:0][DEPTH-1:0]   older_q;

   ptw_key_t         key_q [DEPTH];
   ptw_key_t         alloc_key, resp_key;
   logic [DEPTH-1:0] free_mask, busy_mask, wait_mask, done_mask, resp_hit;
   logic [DEPTH-1:0] issue_pick, wb_pick;
   logic [IDX_W-1:0] alloc_idx, wb_idx;
   logic [CNT_W-1:0] cnt;
   logic             wait_any, done_any, resp_ok, alloc_merge;
   logic             alloc_fire, issue_fire, wb_fire;

   // With a single level the level field never participates in matching.
   function automatic ptw_key_t key_of(input logic [TAG_WIDTH-1:0] t,
                                       input logic [LW-1:0] l);
      ptw_key_t k;
      k     = '0;
      k.tag = KEY_TAG_MAX'(t);
      if (LEVELS > 1) k.level = KEY_LVL_MAX'(l);
      return k;
   endfunction

   // Per-entry masks, response matching and the in-flight credit count.
   always_comb begin
      resp_ok  = resp_valid && (state_q[resp_idx] == ST_INFLIGHT);
      resp_key = key_of(tag_q[resp_idx], lvl_q[resp_idx]);
      cnt      = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         key_q[i]     = key_of(tag_q[i], lvl_q[i]);
         free_mask[i] = (state_q[i] == ST_FREE);
         done_mask[i] = (state_q[i] == ST_DONE);
         resp_hit[i]  = resp_ok && (key_q[i] == resp_key) &&
                        ((state_q[i] == ST_WAIT) || (state_q[i] == ST_MERGED));
         // A WAIT entry completed by this cycle's response must not also issue.
         wait_mask[i] = (state_q[i] == ST_WAIT) && !resp_hit[i];
         if ((state_q[i] == ST_INFLIGHT) || (state_q[i] == ST_ZOMBIE))
            cnt = cnt + CNT_W'(1);
      end
   end

   assign busy_mask    = ~free_mask;
   assign inflight_cnt = cnt;
   assign full         = ~|free_mask;

   age_matrix_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_issue_sel (
      .req(wait_mask), .rows(older_q), .pick(issue_pick), .pick_idx(issue_idx), .any(wait_any)
   );

   age_matrix_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_wb_sel (
      .req(done_mask), .rows(older_q), .pick(wb_pick), .pick_idx(wb_idx), .any(done_any)
   );

   assign issue_valid = wait_any && (inflight_cnt < CNT_W'(MAX_INFLIGHT));
   assign issue_tag   = tag_q[issue_idx];
   assign issue_level = lvl_q[issue_idx];
   assign issue_data  = data_q[issue_idx];

   assign wb_valid  = done_any;
   assign wb_tag    = tag_q[wb_idx];
   assign wb_level  = lvl_q[wb_idx];
   assign wb_data   = data_q[wb_idx];
   assign wb_leader = done_any && leader_q[wb_idx];

   assign alloc_fire = alloc_en && !full && !flush;
   assign issue_fire = issue_valid && issue_ready && !flush;
   assign wb_fire    = wb_valid && wb_ready && !flush;
   assign alloc_idx  = IDX_W'(pencoder(64'(free_mask)));
   assign alloc_key  = key_of(alloc_tag, alloc_level);

   // New entry merges onto a read that stays outstanding past this edge,
   // including one issued this cycle but not one completed this cycle.
   always_comb begin
      alloc_merge = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((key_q[i] == alloc_key) &&
             (((state_q[i] == ST_INFLIGHT) && !(resp_ok && resp_idx == IDX_W'(i))) ||
              (issue_fire && issue_pick[i])))
            alloc_merge = 1'b1;
      end
   end

   // Entry state transitions; flush outranks alloc, issue and write-back.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         state_d[i]  = state_q[i];
         leader_d[i] = leader_q[i];
         case (state_q[i])
            ST_FREE: begin
               if (alloc_fire && alloc_idx == IDX_W'(i)) begin
                  state_d[i]  = alloc_merge ? ST_MERGED : ST_WAIT;
                  leader_d[i] = 1'b0;
               end
            end
            ST_WAIT: begin
               if (flush)                            state_d[i] = ST_FREE;
               else if (resp_hit[i])                 state_d[i] = ST_DONE;
               else if (issue_fire && issue_pick[i]) state_d[i] = ST_INFLIGHT;
               if (!flush && resp_hit[i])            leader_d[i] = 1'b0;
            end
            ST_MERGED: begin
               if (flush)            state_d[i] = ST_FREE;
               else if (resp_hit[i]) begin
                  state_d[i]  = ST_DONE;
                  leader_d[i] = 1'b0;
               end
            end
            ST_INFLIGHT: begin
               if (resp_ok && resp_idx == IDX_W'(i)) begin
                  state_d[i]  = flush ? ST_FREE : ST_DONE;
                  leader_d[i] = 1'b1;
               end else if (flush) begin
                  state_d[i]  = ST_ZOMBIE;
               end
            end
            ST_DONE: begin
               if (flush || (wb_fire && wb_pick[i])) state_d[i] = ST_FREE;
            end
            ST_ZOMBIE: begin
               if (resp_valid && resp_idx == IDX_W'(i)) state_d[i] = ST_FREE;
            end
            default: state_d[i] = ST_FREE;
         endcase
      end
   end

   // State, leader flags and age matrix registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
         leader_q <= '0;
         older_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
         leader_q <= leader_d;
         if (alloc_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (alloc_idx == IDX_W'(i)) older_q[i]            <= busy_mask;
               else                        older_q[i][alloc_idx] <= 1'b0;
            end
         end
      end
   end

   // Payload capture; contents are only meaningful while the entry is busy.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         tag_q[alloc_idx]  <= alloc_tag;
         lvl_q[alloc_idx]  <= alloc_level;
         data_q[alloc_idx] <= alloc_data;
      end
   end

endmodule

// File: tb/tb_ptw_walk_buffer.sv
// Directed self-checking bench for ptw_walk_buffer (default parameters).
module tb_ptw_walk_buffer;

   logic        clk, rst, flush;
   logic        alloc_en;
   logic [17:0] alloc_tag;
   logic        alloc_level;
   logic [47:0] alloc_data;
   logic        full, issue_valid, issue_ready;
   logic [2:0]  issue_idx;
   logic [17:0] issue_tag;
   logic        issue_level;
   logic [47:0] issue_data;
   logic        resp_valid;
   logic [2:0]  resp_idx;
   logic        wb_valid, wb_ready;
   logic [17:0] wb_tag;
   logic        wb_level;
   logic [47:0] wb_data;
   logic        wb_leader;
   logic [1:0]  inflight_cnt;

   int checks = 0;
   int errors = 0;

   ptw_walk_buffer #(.DEPTH(8), .TAG_WIDTH(18), .DATA_WIDTH(48), .LEVELS(2), .MAX_INFLIGHT(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_en(alloc_en), .alloc_tag(alloc_tag), .alloc_level(alloc_level), .alloc_data(alloc_data),
      .full(full), .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_idx(issue_idx),
      .issue_tag(issue_tag), .issue_level(issue_level), .issue_data(issue_data),
      .resp_valid(resp_valid), .resp_idx(resp_idx),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_level(wb_level),
      .wb_data(wb_data), .wb_leader(wb_leader), .inflight_cnt(inflight_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // One clock: inputs set before the call are applied at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
      alloc_en = 1'b0; issue_ready = 1'b0; resp_valid = 1'b0; wb_ready = 1'b0; flush = 1'b0;
      #1;
   endtask

   task automatic do_alloc(input logic [17:0] t, input logic l, input logic [47:0] d);
      alloc_en = 1'b1; alloc_tag = t; alloc_level = l; alloc_data = d;
      tick();
   endtask

   task automatic do_issue();
      issue_ready = 1'b1;
      tick();
   endtask

   task automatic do_resp(input logic [2:0] i);
      resp_valid = 1'b1; resp_idx = i;
      tick();
   endtask

   task automatic do_wb();
      wb_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h exp 0", full); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0h exp 0", issue_valid); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0h exp 0", wb_valid); end
      checks++; if (wb_leader !== 1'b0) begin errors++; $display("FAIL reset_wb_leader: got %0h exp 0", wb_leader); end
      checks++; if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d exp 0", inflight_cnt); end
   endtask

   task automatic test_basic();
      do_alloc(18'h12, 1'b1, 48'h1234_5678_9ABC);
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL basic_issue_valid: got %0h exp 1", issue_valid); end
      checks++; if (issue_idx !== 3'd0) begin errors++; $display("FAIL basic_issue_idx: got %0d exp 0", issue_idx); end
      checks++; if (issue_tag !== 18'h12) begin errors++; $display("FAIL basic_issue_tag: got %0h exp 12", issue_tag); end
      checks++; if (issue_level !== 1'b1) begin errors++; $display("FAIL basic_issue_level: got %0h exp 1", issue_level); end
      checks++; if (issue_data !== 48'h1234_5678_9ABC) begin errors++; $display("FAIL basic_issue_data: got %0h exp 123456789abc", issue_data); end
      do_issue();
      checks++; if (inflight_cnt !== 2'd1) begin errors++; $display("FAIL basic_inflight1: got %0d exp 1", inflight_cnt); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_issue_gone: got %0h exp 0", issue_valid); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_wb_early: got %0h exp 0", wb_valid); end
      do_resp(3'd0);
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL basic_wb_valid: got %0h exp 1", wb_valid); end
      checks++; if (wb_tag !== 18'h12) begin errors++; $display("FAIL basic_wb_tag: got %0h exp 12", wb_tag); end
      checks++; if (wb_level !== 1'b1) begin errors++; $display("FAIL basic_wb_level: got %0h exp 1", wb_level); end
      checks++; if (wb_data !== 48'h1234_5678_9ABC) begin errors++; $display("FAIL basic_wb_data: got %0h exp 123456789abc", wb_data); end
      checks++; if (wb_leader !== 1'b1) begin errors++; $display("FAIL basic_wb_leader: got %0h exp 1", wb_leader); end
      checks++; if (inflight_cnt !== 2'd0) begin errors++; $display("FAIL basic_inflight0: got %0d exp 0", inflight_cnt); end
      do_wb();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL basic_wb_drained: got %0h exp 0", wb_valid); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL basic_full: got %0h exp 0", full); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_empty_issue: got %0h exp 0", issue_valid); end
   endtask

   task automatic test_merge();
      do_alloc(18'h5, 1'b0, 48'hA);
      checks++; if (issue_idx !== 3'd0) begin errors++; $display("FAIL merge_a_idx: got %0d exp 0", issue_idx); end
      do_issue();
      do_alloc(18'h5, 1'b0, 48'hB);
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL merge_b_not_wait: got %0h exp 0", issue_valid); end
      do_alloc(18'h5, 1'b1, 48'hC);
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL merge_c_valid: got %0h exp 1", issue_valid); end
      checks++; if (issue_idx !== 3'd2) begin errors++; $display("FAIL merge_c_idx: got %0d exp 2", issue_idx); end
      do_resp(3'd0);
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL merge_wb_valid: got %0h exp 1", wb_valid); end
      checks++; if (wb_data !== 48'hA) begin errors++; $display("FAIL merge_wb_a_data: got %0h exp a", wb_data); end
      checks++; if (wb_leader !== 1'b1) begin errors++; $display("FAIL merge_wb_a_leader: got %0h exp 1", wb_leader); end
      checks++; if (issue_idx !== 3'd2 || issue_valid !== 1'b1) begin errors++; $display("FAIL merge_c_still: got v%0h idx%0d exp v1 idx2", issue_valid, issue_idx); end
      do_wb();
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL merge_wb_b_valid: got %0h exp 1", wb_valid); end
      checks++; if (wb_data !== 48'hB) begin errors++; $display("FAIL merge_wb_b_data: got %0h exp b", wb_data); end
      checks++; if (wb_leader !== 1'b0) begin errors++; $display("FAIL merge_wb_b_leader: got %0h exp 0", wb_leader); end
      do_wb();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL merge_wb_empty: got %0h exp 0", wb_valid); end
      do_issue();
      do_resp(3'd2);
      checks++; if (wb_data !== 48'hC || wb_level !== 1'b1 || wb_leader !== 1'b1) begin errors++; $display("FAIL merge_wb_c: got d%0h l%0h ld%0h exp dc l1 ld1", wb_data, wb_level, wb_leader); end
      do_wb();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL merge_final_wb: got %0h exp 0", wb_valid); end
   endtask

   task automatic test_credit();
      do_alloc(18'h21, 1'b0, 48'h21);
      do_alloc(18'h22, 1'b0, 48'h22);
      do_alloc(18'h23, 1'b0, 48'h23);
      checks++; if (issue_idx !== 3'd0) begin errors++; $display("FAIL credit_idx0: got %0d exp 0", issue_idx); end
      do_issue();
      checks++; if (issue_idx !== 3'd1) begin errors++; $display("FAIL credit_idx1: got %0d exp 1", issue_idx); end
      do_issue();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL credit_blocked: got %0h exp 0", issue_valid); end
      checks++; if (inflight_cnt !== 2'd2) begin errors++; $display("FAIL credit_cnt2: got %0d exp 2", inflight_cnt); end
      do_resp(3'd0);
      checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd2) begin errors++; $display("FAIL credit_release: got v%0h idx%0d exp v1 idx2", issue_valid, issue_idx); end
      checks++; if (inflight_cnt !== 2'd1) begin errors++; $display("FAIL credit_cnt1: got %0d exp 1", inflight_cnt); end
      issue_ready = 1'b1; resp_valid = 1'b1; resp_idx = 3'd1;
      tick();
      checks++; if (inflight_cnt !== 2'd1) begin errors++; $display("FAIL credit_net_zero: got %0d exp 1", inflight_cnt); end
      checks++; if (wb_tag !== 18'h21) begin errors++; $display("FAIL credit_wb0: got %0h exp 21", wb_tag); end
      do_wb();
      checks++; if (wb_tag !== 18'h22 || wb_valid !== 1'b1) begin errors++; $display("FAIL credit_wb1: got v%0h t%0h exp v1 t22", wb_valid, wb_tag); end
      do_wb();
      do_resp(3'd2);
      checks++; if (wb_tag !== 18'h23) begin errors++; $display("FAIL credit_wb2: got %0h exp 23", wb_tag); end
      do_wb();
      checks++; if (wb_valid !== 1'b0 || inflight_cnt !== 2'd0) begin errors++; $display("FAIL credit_drained: got v%0h c%0d exp v0 c0", wb_valid, inflight_cnt); end
   endtask

   task automatic test_oldest();
      logic [2:0]  ord  [8];
      logic [17:0] otag [8];
      ord  = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd3};
      otag = '{18'h41, 18'h42, 18'h44, 18'h45, 18'h46, 18'h47, 18'h50, 18'h53};
      for (int i = 0; i < 8; i++)
         do_alloc((i == 3) ? 18'h40 : 18'(18'h40 + i), 1'b0, 48'(48'h100 + i));
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL oldest_full: got %0h exp 1", full); end
      checks++; if (issue_idx !== 3'd0) begin errors++; $display("FAIL oldest_first: got %0d exp 0", issue_idx); end
      do_issue();
      do_resp(3'd0);
      checks++; if (wb_data !== 48'h100 || wb_leader !== 1'b1) begin errors++; $display("FAIL oldest_wb0: got d%0h ld%0h exp d100 ld1", wb_data, wb_leader); end
      do_wb();
      checks++; if (wb_data !== 48'h103 || wb_leader !== 1'b0) begin errors++; $display("FAIL oldest_wb3: got d%0h ld%0h exp d103 ld0", wb_data, wb_leader); end
      do_wb();
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL oldest_not_full: got %0h exp 0", full); end
      do_alloc(18'h50, 1'b0, 48'h150);
      do_alloc(18'h53, 1'b0, 48'h153);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL oldest_refull: got %0h exp 1", full); end
      for (int k = 0; k < 8; k++) begin
         checks++; if (issue_valid !== 1'b1 || issue_idx !== ord[k] || issue_tag !== otag[k]) begin
            errors++; $display("FAIL oldest_order[%0d]: got v%0h idx%0d t%0h exp v1 idx%0d t%0h", k, issue_valid, issue_idx, issue_tag, ord[k], otag[k]);
         end
         do_issue();
         do_resp(ord[k]);
         do_wb();
      end
      checks++; if (full !== 1'b0 || issue_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL oldest_empty: got f%0h i%0h w%0h exp 0 0 0", full, issue_valid, wb_valid); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) do_alloc(18'(18'h61 + i), 1'b0, 48'(48'h61 + i));
      do_issue();
      do_issue();
      checks++; if (inflight_cnt !== 2'd2) begin errors++; $display("FAIL flush_pre_cnt: got %0d exp 2", inflight_cnt); end
      flush = 1'b1;
      tick();
      checks++; if (issue_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_outputs: got i%0h w%0h exp 0 0", issue_valid, wb_valid); end
      checks++; if (inflight_cnt !== 2'd2) begin errors++; $display("FAIL flush_zombie_cnt: got %0d exp 2", inflight_cnt); end
      for (int i = 0; i < 5; i++) do_alloc(18'(18'h70 + i), 1'b0, 48'h0);
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL flush_five_free: got %0h exp 0", full); end
      do_alloc(18'h75, 1'b0, 48'h0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL flush_zombie_full: got %0h exp 1", full); end
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_credit_held: got %0h exp 0", issue_valid); end
      flush = 1'b1;
      tick();
      do_resp(3'd0);
      checks++; if (wb_valid !== 1'b0 || inflight_cnt !== 2'd1) begin errors++; $display("FAIL flush_resp0: got w%0h c%0d exp w0 c1", wb_valid, inflight_cnt); end
      do_resp(3'd1);
      checks++; if (wb_valid !== 1'b0 || inflight_cnt !== 2'd0 || full !== 1'b0 || issue_valid !== 1'b0) begin
         errors++; $display("FAIL flush_empty: got w%0h c%0d f%0h i%0h exp 0 0 0 0", wb_valid, inflight_cnt, full, issue_valid);
      end
      do_alloc(18'h66, 1'b0, 48'h66);
      do_issue();
      flush = 1'b1; resp_valid = 1'b1; resp_idx = 3'd0;
      tick();
      checks++; if (inflight_cnt !== 2'd0 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_with_resp: got c%0d w%0h exp c0 w0", inflight_cnt, wb_valid); end
   endtask

   task automatic test_back_to_back();
      do_alloc(18'h31, 1'b0, 48'hA1);
      checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd0) begin errors++; $display("FAIL b2b_a_issue: got v%0h idx%0d exp v1 idx0", issue_valid, issue_idx); end
      issue_ready = 1'b1;
      alloc_en = 1'b1; alloc_tag = 18'h31; alloc_level = 1'b0; alloc_data = 48'hB1;
      tick();
      checks++; if (issue_valid !== 1'b0 || inflight_cnt !== 2'd1) begin errors++; $display("FAIL b2b_merge_on_issue: got v%0h c%0d exp v0 c1", issue_valid, inflight_cnt); end
      do_resp(3'd0);
      checks++; if (wb_data !== 48'hA1 || wb_leader !== 1'b1) begin errors++; $display("FAIL b2b_wb_a: got d%0h ld%0h exp da1 ld1", wb_data, wb_leader); end
      do_wb();
      checks++; if (wb_valid !== 1'b1 || wb_data !== 48'hB1 || wb_leader !== 1'b0) begin errors++; $display("FAIL b2b_wb_b: got v%0h d%0h ld%0h exp v1 db1 ld0", wb_valid, wb_data, wb_leader); end
      do_wb();
      do_alloc(18'h32, 1'b0, 48'hC2);
      do_issue();
      resp_valid = 1'b1; resp_idx = 3'd0;
      alloc_en = 1'b1; alloc_tag = 18'h32; alloc_level = 1'b0; alloc_data = 48'hD2;
      tick();
      checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd1 || issue_tag !== 18'h32) begin
         errors++; $display("FAIL b2b_wait_on_resp: got v%0h idx%0d t%0h exp v1 idx1 t32", issue_valid, issue_idx, issue_tag);
      end
      checks++; if (wb_valid !== 1'b1 || wb_data !== 48'hC2 || wb_leader !== 1'b1) begin errors++; $display("FAIL b2b_wb_c: got v%0h d%0h ld%0h exp v1 dc2 ld1", wb_valid, wb_data, wb_leader); end
      do_wb();
      do_issue();
      do_resp(3'd1);
      checks++; if (wb_data !== 48'hD2 || wb_leader !== 1'b1) begin errors++; $display("FAIL b2b_wb_d: got d%0h ld%0h exp dd2 ld1", wb_data, wb_leader); end
      do_wb();
      checks++; if (wb_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL b2b_empty: got w%0h f%0h exp 0 0", wb_valid, full); end
   endtask

   task automatic test_full_reset();
      for (int i = 0; i < 8; i++) do_alloc(18'(18'h80 + i), 1'b0, 48'(48'h80 + i));
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %0h exp 1", full); end
      do_alloc(18'h7F, 1'b1, 48'hDEAD);
      checks++; if (full !== 1'b1 || issue_idx !== 3'd0 || issue_tag !== 18'h80) begin
         errors++; $display("FAIL full_drop: got f%0h idx%0d t%0h exp f1 idx0 t80", full, issue_idx, issue_tag);
      end
      do_issue();
      checks++; if (inflight_cnt !== 2'd1) begin errors++; $display("FAIL full_midtraffic: got %0d exp 1", inflight_cnt); end
      rst = 1'b0;
      wb_ready = 1'b1; issue_ready = 1'b1;
      tick();
      rst = 1'b1;
      checks++; if (full !== 1'b0 || issue_valid !== 1'b0 || wb_valid !== 1'b0 || wb_leader !== 1'b0 || inflight_cnt !== 2'd0) begin
         errors++; $display("FAIL full_reset_outputs: got f%0h i%0h w%0h ld%0h c%0d exp all 0", full, issue_valid, wb_valid, wb_leader, inflight_cnt);
      end
      do_alloc(18'h90, 1'b0, 48'h90);
      checks++; if (issue_valid !== 1'b1 || issue_idx !== 3'd0 || issue_tag !== 18'h90) begin
         errors++; $display("FAIL full_after_reset: got v%0h idx%0d t%0h exp v1 idx0 t90", issue_valid, issue_idx, issue_tag);
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; alloc_en = 1'b0; alloc_tag = '0; alloc_level = 1'b0; alloc_data = '0;
      issue_ready = 1'b0; resp_valid = 1'b0; resp_idx = '0; wb_ready = 1'b0;
      test_reset();
      test_basic();
      test_merge();
      test_credit();
      test_oldest();
      test_flush();
      test_back_to_back();
      test_full_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
